// File: rtl/uart_bridge_pkg.sv
// Shared constants and types for the UART host bridge.
//   - UART core register addresses and STATUS bit positions
//   - bridge polling FSM state encoding
//   - helper that maps an FSM state to the core register it addresses
package uart_bridge_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] UART_ADDR_TX     = 2'd0;
  localparam logic [1:0] UART_ADDR_RX     = 2'd1;
  localparam logic [1:0] UART_ADDR_STATUS = 2'd2;

  localparam int unsigned STAT_RX_READY = 0;
  localparam int unsigned STAT_TX_BUSY  = 1;

  typedef enum logic [1:0] {
    ST_POLL  = 2'd0,
    ST_RD_RX = 2'd1,
    ST_WR_TX = 2'd2,
    ST_HOLD  = 2'd3
  } bridge_state_e;

  // Core register addressed while the FSM sits in a given state.
  function automatic logic [1:0] state_addr(input bridge_state_e st);
    case (st)
      ST_RD_RX: state_addr = UART_ADDR_RX;
      ST_WR_TX: state_addr = UART_ADDR_TX;
      default:  state_addr = UART_ADDR_STATUS;
    endcase
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// First-word fall-through byte FIFO with occupancy output.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   i_push/i_data - write strobe and byte (ignored while full)
//   i_pop         - dequeue head (ignored while empty)
//   o_data        - current head byte
//   o_full/o_empty/o_level - status and occupancy
module uart_byte_fifo
  import uart_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic [BYTE_W-1:0]         i_data,
  input  logic                      i_pop,
  output logic [BYTE_W-1:0]         o_data,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [$clog2(DEPTH):0]    o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_count;
  logic              w_push;
  logic              w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == LW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_level = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Storage is cleared on reset so the head reads 0x00 while empty after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[AW'(i)] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + LW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - LW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_host_bridge.sv
// Buffered host-side front end for the UART core register port.
// A TX FIFO and an RX FIFO decouple valid/ready clients from the core; a
// polling FSM (POLL -> RD_RX|WR_TX -> HOLD -> POLL) moves bytes between them.
// Ports:
//   clk, rst                          - clock, asynchronous active-high reset
//   s_tx_data/s_tx_valid/s_tx_ready   - TX byte stream in
//   m_rx_data/m_rx_valid/m_rx_ready   - RX byte stream out (fall-through)
//   core_wr/core_addr/core_wdata      - registered strobes to the UART core
//   core_rdata                        - combinational core readback
//   tx_level/rx_level                 - FIFO occupancies
//   rx_overrun/overrun_clr            - sticky RX backpressure flag and clear
// Optional build macro UART_BRIDGE_STATS_EN adds tx_count/rx_count outputs.
module uart_host_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned TX_DEPTH = 16,
  parameter int unsigned RX_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  s_tx_data,
  input  logic                        s_tx_valid,
  output logic                        s_tx_ready,
  output logic [7:0]                  m_rx_data,
  output logic                        m_rx_valid,
  input  logic                        m_rx_ready,
  output logic                        core_wr,
  output logic [1:0]                  core_addr,
  output logic [7:0]                  core_wdata,
  input  logic [7:0]                  core_rdata,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  output logic [$clog2(RX_DEPTH):0]   rx_level,
  output logic                        rx_overrun,
  input  logic                        overrun_clr
`ifdef UART_BRIDGE_STATS_EN
  ,
  output logic [15:0]                 tx_count,
  output logic [15:0]                 rx_count
`endif
);

  bridge_state_e r_state;
  bridge_state_e w_state_next;
  logic          r_core_wr;
  logic [1:0]    r_core_addr;
  logic [7:0]    r_core_wdata;
  logic          r_rx_overrun;

  logic          w_tx_pop;
  logic          w_ovr_set;
  logic [7:0]    w_tx_head;
  logic          w_tx_full;
  logic          w_tx_empty;
  logic          w_rx_push;
  logic          w_rx_full;
  logic          w_rx_empty;
  logic          w_stat_rx_ready;
  logic          w_stat_tx_busy;

  assign w_stat_rx_ready = core_rdata[STAT_RX_READY];
  assign w_stat_tx_busy  = core_rdata[STAT_TX_BUSY];
  assign w_rx_push       = (r_state == ST_RD_RX);

  uart_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (s_tx_valid),
    .i_data  (s_tx_data),
    .i_pop   (w_tx_pop),
    .o_data  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_level (tx_level)
  );

  uart_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rx_push),
    .i_data  (core_rdata),
    .i_pop   (m_rx_ready),
    .o_data  (m_rx_data),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_level (rx_level)
  );

  assign s_tx_ready = !w_tx_full;
  assign m_rx_valid = !w_rx_empty;
  assign core_wr    = r_core_wr;
  assign core_addr  = r_core_addr;
  assign core_wdata = r_core_wdata;
  assign rx_overrun = r_rx_overrun;

  // Next-state logic; RX service takes priority over TX.
  always_comb begin
    w_state_next = r_state;
    w_tx_pop     = 1'b0;
    w_ovr_set    = 1'b0;
    case (r_state)
      ST_POLL: begin
        w_ovr_set = w_stat_rx_ready && w_rx_full;
        if (w_stat_rx_ready && !w_rx_full) begin
          w_state_next = ST_RD_RX;
        end else if (!w_stat_tx_busy && !w_tx_empty) begin
          w_state_next = ST_WR_TX;
          w_tx_pop     = 1'b1;
        end
      end
      ST_RD_RX: w_state_next = ST_HOLD;
      ST_WR_TX: w_state_next = ST_HOLD;
      ST_HOLD:  w_state_next = ST_POLL;
      default:  w_state_next = ST_POLL;
    endcase
  end

  // State register; core strobes are registered from the next state so they
  // switch cleanly together with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_POLL;
      r_core_wr    <= 1'b0;
      r_core_addr  <= UART_ADDR_STATUS;
      r_core_wdata <= '0;
      r_rx_overrun <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_core_wr    <= (w_state_next == ST_RD_RX) || (w_state_next == ST_WR_TX);
      r_core_addr  <= state_addr(w_state_next);
      if (w_tx_pop) begin
        r_core_wdata <= w_tx_head;
      end
      // Set wins over clear.
      if (w_ovr_set) begin
        r_rx_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_rx_overrun <= 1'b0;
      end
    end
  end

`ifdef UART_BRIDGE_STATS_EN
  logic [15:0] r_tx_count;
  logic [15:0] r_rx_count;

  // Wrapping transfer counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_count <= '0;
      r_rx_count <= '0;
    end else begin
      if (r_state == ST_WR_TX) begin
        r_tx_count <= r_tx_count + 16'd1;
      end
      if (r_state == ST_RD_RX) begin
        r_rx_count <= r_rx_count + 16'd1;
      end
    end
  end

  assign tx_count = r_tx_count;
  assign rx_count = r_rx_count;
`endif

endmodule
